// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//   Instruction fetch front end. Issues sequential fetch requests to the
//   instruction SRAM, tracks in-flight requests in a pending-pc FIFO, and
//   buffers returned {pc, inst} pairs in a circular queue that feeds decode.
//   A redirect flushes the queue, reloads the pc, and marks every request
//   still in flight as stale so its response is dropped on arrival.
//
// Parameters
//   FQ_DEPTH  : instruction queue entries (power of 2, >= 2)
//   MAX_OUTST : max in-flight requests (1..FQ_DEPTH)
//   RESET_PC  : first fetch address after reset
//
// Ports
//   clk, resetn                 clock, async active-low reset
//   redirect_valid/redirect_pc  flush queue and restart fetch
//   inst_sram_req/addr          fetch request and address (= pc)
//   inst_sram_addr_ok           request accepted this cycle
//   inst_sram_data_ok/rdata     in-order response
//   fs_to_ds_valid/pc/inst      queue head to decode
//   ds_allowin                  decode consumes the head
//   fq_count                    occupied queue entries
//
// Build option
//   FQ_BYPASS_EN : when the queue is empty, a live response is presented to
//                  decode in the same cycle; if decode takes it, it is not
//                  written into the queue.
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int          FQ_DEPTH  = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'hbfc00000
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       inst_sram_req,
    output logic [31:0]                inst_sram_addr,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata,
    output logic                       fs_to_ds_valid,
    output logic [31:0]                fs_to_ds_pc,
    output logic [31:0]                fs_to_ds_inst,
    input  logic                       ds_allowin,
    output logic [$clog2(FQ_DEPTH):0]  fq_count
);

    localparam int AW = $clog2(FQ_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int OW = $clog2(MAX_OUTST + 1);

    logic [31:0]   pc_q, pc_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] disc_q, disc_d;
    logic [PW-1:0] pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
    logic [AW-1:0] fq_head_q, fq_head_d, fq_tail_q, fq_tail_d;
    logic [CW-1:0] fq_cnt_q, fq_cnt_d;

    logic [31:0] pend_mem    [MAX_OUTST];
    logic [31:0] fq_pc_mem   [FQ_DEPTH];
    logic [31:0] fq_inst_mem [FQ_DEPTH];

    logic [31:0] occ;
    logic        addr_hs, resp, stale, resp_keep, byp, fq_empty;
    logic        fq_push, fq_pop;
    logic [31:0] resp_pc;

    function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
    endfunction

    // Entries already claimed: queued words plus live (non-stale) in-flight
    // requests. Stale requests will never land in the queue.
    assign occ      = 32'(fq_cnt_q) + 32'(outst_q) - 32'(disc_q);

    // resetn gating keeps req low while reset is held. Nothing here depends
    // on ds_allowin, so there is no decode-to-SRAM combinational path.
    assign inst_sram_req  = resetn && !redirect_valid &&
                            (32'(outst_q) < 32'(MAX_OUTST)) &&
                            (occ < 32'(FQ_DEPTH));
    assign inst_sram_addr = pc_q;

    assign addr_hs   = inst_sram_req && inst_sram_addr_ok;
    assign resp      = inst_sram_data_ok && (outst_q != '0);  // data_ok with nothing in flight is ignored
    assign stale     = (disc_q != '0);
    assign resp_keep = resp && !stale && !redirect_valid;
    assign resp_pc   = pend_mem[pend_rd_q];
    assign fq_empty  = (fq_cnt_q == '0);

`ifdef FQ_BYPASS_EN
    assign byp = fq_empty && resp_keep;
`else
    assign byp = 1'b0;
`endif

    assign fs_to_ds_valid = !redirect_valid && (!fq_empty || byp);
    assign fs_to_ds_pc    = byp ? resp_pc         : fq_pc_mem[fq_head_q];
    assign fs_to_ds_inst  = byp ? inst_sram_rdata : fq_inst_mem[fq_head_q];
    assign fq_count       = fq_cnt_q;

    // A bypassed word taken by decode never enters the queue.
    assign fq_push = resp_keep && !(byp && ds_allowin);
    assign fq_pop  = fs_to_ds_valid && ds_allowin && !byp;

    always_comb begin
        pc_d      = pc_q;
        outst_d   = outst_q;
        disc_d    = disc_q;
        pend_rd_d = pend_rd_q;
        pend_wr_d = pend_wr_q;
        fq_head_d = fq_head_q;
        fq_tail_d = fq_tail_q;
        fq_cnt_d  = fq_cnt_q;

        if (addr_hs) begin
            pc_d      = pc_q + 32'd4;
            pend_wr_d = pend_inc(pend_wr_q);
        end
        if (resp)
            pend_rd_d = pend_inc(pend_rd_q);
        outst_d = outst_q + OW'(addr_hs) - OW'(resp);

        if (redirect_valid) begin
            // Everything still outstanding after this cycle is stale.
            pc_d      = redirect_pc;
            disc_d    = outst_q - OW'(resp);
            fq_head_d = '0;
            fq_tail_d = '0;
            fq_cnt_d  = '0;
        end else begin
            if (resp && stale)
                disc_d = disc_q - OW'(1);
            if (fq_push)
                fq_tail_d = fq_tail_q + AW'(1);
            if (fq_pop)
                fq_head_d = fq_head_q + AW'(1);
            fq_cnt_d = fq_cnt_q + CW'(fq_push) - CW'(fq_pop);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q      <= RESET_PC;
            outst_q   <= '0;
            disc_q    <= '0;
            pend_rd_q <= '0;
            pend_wr_q <= '0;
            fq_head_q <= '0;
            fq_tail_q <= '0;
            fq_cnt_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            outst_q   <= outst_d;
            disc_q    <= disc_d;
            pend_rd_q <= pend_rd_d;
            pend_wr_q <= pend_wr_d;
            fq_head_q <= fq_head_d;
            fq_tail_q <= fq_tail_d;
            fq_cnt_q  <= fq_cnt_d;
        end
    end

    // Storage needs no reset: pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (addr_hs)
            pend_mem[pend_wr_q] <= pc_q;
        if (fq_push) begin
            fq_pc_mem[fq_tail_q]   <= resp_pc;
            fq_inst_mem[fq_tail_q] <= inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

    localparam int          FQ_DEPTH  = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [31:0] RESET_PC  = 32'hbfc00000;
`ifdef FQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk, resetn, redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        fs_to_ds_valid;
    logic [31:0] fs_to_ds_pc, fs_to_ds_inst;
    logic        ds_allowin;
    logic [$clog2(FQ_DEPTH):0] fq_count;

    inst_fetch_queue #(.FQ_DEPTH(FQ_DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .resetn(resetn),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_pc(fs_to_ds_pc), .fs_to_ds_inst(fs_to_ds_inst),
        .ds_allowin(ds_allowin), .fq_count(fq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } dec_t;
    typedef struct { logic [31:0] pc; bit stale; } fl_t;

    dec_t        sb_q[$];   // expected decode deliveries, in order
    fl_t         infl[$];   // model of requests in flight
    logic [31:0] m_pc;
    int          m_cnt;     // model queue occupancy
    int          nvec, nerr;
    int          p_redir, p_aok, p_dok, p_allow;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return (pc * 32'h9e3779b1) ^ 32'h24020001;
    endfunction

    function automatic int live_inflight();
        int n = 0;
        foreach (infl[i]) if (!infl[i].stale) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        infl.delete();
        sb_q.delete();
        m_pc  = RESET_PC;
        m_cnt = 0;
    endtask

    // Assert reset mid-cycle; outputs must drop at once and stay in reset state.
    task automatic do_reset(input int cycles);
        @(negedge clk);
        resetn = 1'b0;
        redirect_valid = 0; inst_sram_addr_ok = 0; inst_sram_data_ok = 0; ds_allowin = 0;
        model_reset();
        for (int c = 0; c < cycles; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            chk("rst_req",   32'(inst_sram_req),  32'd0);
            chk("rst_valid", 32'(fs_to_ds_valid), 32'd0);
            chk("rst_count", 32'(fq_count),       32'd0);
            chk("rst_addr",  inst_sram_addr,      RESET_PC);
        end
        resetn = 1'b1;
    endtask

    task automatic step();
        logic [31:0] rv;
        bit redir, aok, dok, allow, req_exp, resp, keep, byp, v_exp;
        fl_t head;
        @(negedge clk);
        redir = ($urandom_range(99) < p_redir);
        aok   = ($urandom_range(99) < p_aok);
        dok   = ($urandom_range(99) < p_dok);
        allow = ($urandom_range(99) < p_allow);
        rv    = $urandom;
        redirect_valid    = redir;
        redirect_pc       = {rv[31:2], 2'b00};
        inst_sram_addr_ok = aok;
        inst_sram_data_ok = dok;
        ds_allowin        = allow;
        inst_sram_rdata   = (infl.size() > 0) ? inst_of(infl[0].pc) : $urandom;
        #1;

        req_exp = !redir && (infl.size() < MAX_OUTST) && (m_cnt + live_inflight() < FQ_DEPTH);
        resp    = dok && (infl.size() > 0);
        keep    = 1'b0;
        if (resp) begin
            head = infl[0];
            keep = !head.stale && !redir;
        end
        byp   = BYP && (m_cnt == 0) && keep;
        v_exp = !redir && (m_cnt > 0 || byp);

        chk("req", 32'(inst_sram_req), 32'(req_exp));
        if (req_exp) chk("addr", inst_sram_addr, m_pc);
        chk("valid", 32'(fs_to_ds_valid), 32'(v_exp));
        chk("count", 32'(fq_count), 32'(m_cnt));

        if (resp) void'(infl.pop_front());
        if (redir) begin
            foreach (infl[i]) infl[i].stale = 1'b1;
            m_pc  = redirect_pc;
            m_cnt = 0;
            sb_q.delete();
        end else begin
            if (keep) begin
                sb_q.push_back('{pc: head.pc, inst: inst_of(head.pc)});
                if (!(byp && allow)) m_cnt++;
            end
            if (v_exp && allow && !byp) m_cnt--;
            if (req_exp && aok) begin
                infl.push_back('{pc: m_pc, stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Monitor: whenever decode takes a word, it must be the next expected one.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (resetn && fs_to_ds_valid && ds_allowin) begin
                if (sb_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL dec_unexpected: got pc %h expected no delivery", fs_to_ds_pc);
                end else begin
                    dec_t e;
                    e = sb_q.pop_front();
                    chk("dec_pc",   fs_to_ds_pc,   e.pc);
                    chk("dec_inst", fs_to_ds_inst, e.inst);
                end
            end
        end
    end

    task automatic run(input int n, input int pr, input int pa, input int pd, input int pl);
        p_redir = pr; p_aok = pa; p_dok = pd; p_allow = pl;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        nvec = 0; nerr = 0;
        resetn = 1'b0; redirect_valid = 0; redirect_pc = '0;
        inst_sram_addr_ok = 0; inst_sram_data_ok = 0; inst_sram_rdata = '0; ds_allowin = 0;
        model_reset();
        do_reset(3);

        run(30, 0, 100, 100, 100);   // streaming, one fetch per cycle
        run(12, 0, 100, 100, 0);     // decode stalled: queue fills, req drops
        run(1,  0, 100, 0,   100);   // single pop, req returns
        run(6,  0, 100, 100, 100);
        run(3,  0, 100, 0,   100);   // requests in flight, no responses
        run(1,  100, 0, 0,   100);   // redirect with words outstanding
        run(10, 0, 100, 100, 100);
        run(3,  0, 100, 0,   100);
        run(1,  100, 0, 100, 100);   // redirect coinciding with a response
        run(10, 0, 100, 100, 100);
        do_reset(2);                 // reset while requests are in flight
        run(10, 0, 100, 100, 100);

        for (int seg = 0; seg < 80; seg++) begin
            run(40, $urandom_range(15), $urandom_range(30, 100),
                $urandom_range(20, 100), $urandom_range(0, 100));
            if ($urandom_range(9) == 0) do_reset(1);
        end
        run(20, 0, 100, 100, 100);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
